// File: rtl/digit_serial_sub_if.sv
// Handshake bundle for digit_serial_sub: operand request channel and result channel.
// The master side supplies operands and consumes results; the slave side is the subtractor.
interface digit_serial_sub_if #(
    parameter int DIGITS = 4
);
    localparam int W = 3 * DIGITS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow_out;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow_out
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow_out
    );
endinterface

// File: rtl/digit_serial_sub.sv
// Digit-serial A - B: one 3-bit subtract-with-borrow slice iterated LSB digit first.
// Define DSUB_SAT_EN to clamp diff to zero when the final borrow reports underflow.
module digit_serial_sub #(
    parameter int DIGITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    digit_serial_sub_if.slave  bus
);
    localparam int W  = 3 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-1:0]  res_sh;
    logic          brw;
    logic [CW-1:0] cnt;

    logic          in_ready_q;
    logic          out_valid_q;
    logic [W-1:0]  diff_q;
    logic          borrow_q;

    logic [3:0]    t;
    logic [W-1:0]  res_next;
    logic [W-1:0]  diff_next;

    // One digit of subtract-with-borrow; t[3] is the borrow into the next digit.
    always_comb begin
        t         = {1'b0, a_sh[2:0]} - {1'b0, b_sh[2:0]} - {3'b000, brw};
        res_next  = res_sh >> 3;
        res_next[W-1 -: 3] = t[2:0];
`ifdef DSUB_SAT_EN
        diff_next = t[3] ? '0 : res_next;
`else
        diff_next = res_next;
`endif
    end

    // NOTE: every register here is sequential state, so only non-blocking assignments are used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            a_sh        <= '0;
            b_sh        <= '0;
            res_sh      <= '0;
            brw         <= 1'b0;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_sh       <= bus.a;
                        b_sh       <= bus.b;
                        res_sh     <= '0;
                        brw        <= 1'b0;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 3;
                    b_sh   <= b_sh >> 3;
                    res_sh <= res_next;
                    brw    <= t[3];
                    cnt    <= cnt + CW'(1);
                    // Final digit: publish the result registers alongside the state change.
                    if (cnt == LAST) begin
                        out_valid_q <= 1'b1;
                        diff_q      <= diff_next;
                        borrow_q    <= t[3];
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
endmodule

// File: tb/tb_digit_serial_sub.sv
// Scoreboard bench for digit_serial_sub: driver pushes model results, monitor pops on output handshakes.
// Build with DSUB_SAT_EN defined to check the saturating variant.
module tb_digit_serial_sub;
    localparam int DIGITS = 4;
    localparam int W      = 3 * DIGITS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    digit_serial_sub_if #(.DIGITS(DIGITS)) bus ();
    digit_serial_sub #(.DIGITS(DIGITS)) dut (.clk(clk), .rst(rst), .bus(bus));

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc   = 0;
    int         last_acc = 0;
    bit         rand_ready = 1'b0;
    logic [W:0] sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got timeout expected event (t=%0t)", name, $time);
    endtask

    // Reference: unsigned difference modulo 2^W, borrow iff a < b.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] d;
        logic         bo;
        bo = (a < b);
        d  = a - b;
`ifdef DSUB_SAT_EN
        if (bo) d = '0;
`endif
        return {bo, d};
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) timeout("accept");
        else begin
            sb.push_back(model(a, b));
            last_acc = cyc + 1;
        end
        if (!keep) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_out(input string name);
        int n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) timeout(name);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain", (W+1)'(sb.size()), '0);
    endtask

    // Monitor: compares every accepted result against the oldest expected entry.
    initial begin : monitor
        logic [W:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got %0h expected none", {bus.borrow_out, bus.diff});
                end else begin
                    e = sb.pop_front();
                    check("result", {bus.borrow_out, bus.diff}, e);
                end
            end
        end
    end

    initial begin : ready_gen
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int acc1;
        bit saw;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;

        #3;
        check("reset_in_ready",  (W+1)'(bus.in_ready),   (W+1)'(1));
        check("reset_out_valid", (W+1)'(bus.out_valid),  '0);
        check("reset_diff",      (W+1)'(bus.diff),       '0);
        check("reset_borrow",    (W+1)'(bus.borrow_out), '0);
        @(negedge clk);
        @(negedge clk);
        rst           = 1'b0;
        bus.out_ready = 1'b1;

        // Basic result and latency.
        send(12'h123, 12'h045, 1'b0);
        while (!bus.out_valid && (cyc - last_acc) < 50) begin
            check("in_ready_busy", (W+1)'(bus.in_ready), '0);
            @(negedge clk);
        end
        check("latency", (W+1)'(cyc - last_acc), (W+1)'(DIGITS));
        check("diff_0DE", {bus.borrow_out, bus.diff}, {1'b0, 12'h0DE});
        drain();

        // Underflow.
        send(12'h000, 12'h001, 1'b0);
        wait_out("underflow_wait");
`ifdef DSUB_SAT_EN
        check("underflow", {bus.borrow_out, bus.diff}, {1'b1, 12'h000});
`else
        check("underflow", {bus.borrow_out, bus.diff}, {1'b1, 12'hFFF});
`endif
        drain();

        // Back-to-back with out_ready high: accepts are DIGITS+2 cycles apart.
        send(12'hFFF, 12'hFFF, 1'b1);
        acc1 = last_acc;
        send(12'h800, 12'h7FF, 1'b0);
        check("throughput", (W+1)'(last_acc - acc1), (W+1)'(DIGITS + 2));
        drain();

        // Backpressure: result held, in_valid ignored.
        bus.out_ready = 1'b0;
        send(12'h400, 12'h001, 1'b0);
        wait_out("hold_wait");
        repeat (5) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.a        = W'($urandom());
            bus.b        = W'($urandom());
            check("hold_valid",    (W+1)'(bus.out_valid), (W+1)'(1));
            check("hold_diff",     {bus.borrow_out, bus.diff}, {1'b0, 12'h3FF});
            check("hold_in_ready", (W+1)'(bus.in_ready), '0);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("release_valid",    (W+1)'(bus.out_valid), '0);
        check("release_in_ready", (W+1)'(bus.in_ready),  (W+1)'(1));
        drain();

        // Reset during digit 2 aborts the operation.
        send(12'h555, 12'h111, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        sb.delete();
        check("abort_in_ready",  (W+1)'(bus.in_ready),   (W+1)'(1));
        check("abort_out_valid", (W+1)'(bus.out_valid),  '0);
        check("abort_diff",      (W+1)'(bus.diff),       '0);
        check("abort_borrow",    (W+1)'(bus.borrow_out), '0);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (DIGITS + 2) begin
            @(negedge clk);
            if (bus.out_valid) saw = 1'b1;
        end
        check("abort_no_pulse", (W+1)'(saw), '0);
        send(12'h007, 12'h003, 1'b0);
        wait_out("fresh_wait");
        check("fresh_diff", {bus.borrow_out, bus.diff}, {1'b0, 12'h004});
        drain();

        // Randomized traffic with random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            send(W'($urandom()), W'($urandom()), 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        rand_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
